inv_subbytes_seq: RTL and testbench

- Sequences the InvSubBytes step of the AES-256 decryption round over a 128-bit state.
- Time-multiplexes LANES instances of the combinational 8-bit inverse S-box, so area can be traded for latency.
- Sits between the InvShiftRows output and the AddRoundKey input of the decryption datapath.
- Uses valid/ready handshakes on both sides.

---
 rtl/inv_subbytes_seq.sv | 130 +++++++++++++
 tb/tb_inv_subbytes_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq
//   Applies the AES inverse S-box to every byte of a 128-bit state, using LANES
//   combinational S-box instances over STEPS = 16/LANES cycles. Sits between
//   InvShiftRows and AddRoundKey in the decryption datapath.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (overrides abort and handshakes)
//   abort      synchronous flush to IDLE; the block in flight is discarded
//   in_valid   state_in is valid
//   in_ready   a new state can be accepted (IDLE)
//   state_in   input state, byte k = bits [8k+7:8k]
//   out_valid  state_out holds a completed block (DONE)
//   out_ready  downstream accepts state_out
//   state_out  substituted state; mirrors the internal buffer in every state
//   busy       substitution in progress (RUN)
module inv_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Inverse S-box, row-major from 0x00, first entry in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bit offset (255-x)*8; for an 8-bit x, 255-x is simply ~x.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {~x, 3'b000};
    return INV_SBOX_TBL[pos +: 8];
  endfunction

  logic [1:0]    state_q;
  logic [SW-1:0] step_q;
  logic [127:0]  buf_q;
  logic [127:0]  buf_sub;

  // Substitute the LANES bytes selected by the step counter; others pass through.
  always_comb begin
    buf_sub = buf_q;
    for (int l = 0; l < LANES; l++) begin
      buf_sub[(int'(step_q) * LANES + l) * 8 +: 8] =
        inv_sbox(buf_q[(int'(step_q) * LANES + l) * 8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      buf_q   <= '0;
    end else if (abort) begin
      // Flush wins over any coincident accept or transfer; buf is kept.
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q   <= state_in;
            step_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          buf_q <= buf_sub;
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            state_q <= DONE;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign state_out = buf_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq
//   Directed bench for inv_subbytes_seq. Three instances (LANES = 4, 1, 16)
//   share the input side; each has its own outputs. Expected states are
//   hand-computed from the inverse S-box.
module tb_inv_subbytes_seq;

  logic         clk = 1'b0;
  logic         rst_n, abort, in_valid, out_ready;
  logic [127:0] state_in;

  logic         rdy4, ov4, busy4;
  logic [127:0] so4;
  logic         rdy1, ov1, busy1;
  logic [127:0] so1;
  logic         rdy16, ov16, busy16;
  logic [127:0] so16;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] IN_SEQ  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] EXP_SEQ = 128'hfbd7f3819ea340bf38a53630d56a0952;
  localparam logic [127:0] IN_HI   = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [127:0] EXP_HI  = 128'h7d0c2155631469e126d677ba7e042b17;

  always #5 clk = ~clk;

  inv_subbytes_seq #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(rdy4),
    .state_in(state_in), .out_valid(ov4), .out_ready(out_ready), .state_out(so4), .busy(busy4));

  inv_subbytes_seq #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(rdy1),
    .state_in(state_in), .out_valid(ov1), .out_ready(out_ready), .state_out(so1), .busy(busy1));

  inv_subbytes_seq #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(rdy16),
    .state_in(state_in), .out_valid(ov16), .out_ready(out_ready), .state_out(so16), .busy(busy16));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one block into all instances (all must be idle), then watch 24 cycles
  // recording the first out_valid cycle and data of each instance.
  task automatic run_all(input logic [127:0] din, input logic [127:0] exp, input string nm);
    int lat4, lat1, lat16;
    logic [127:0] c4, c1, c16;
    lat4 = -1; lat1 = -1; lat16 = -1;
    c4 = '0; c1 = '0; c16 = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = din;
    @(negedge clk);
    in_valid  = 1'b0;
    state_in  = ~din;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (ov4  && lat4  < 0) begin lat4  = n; c4  = so4;  end
      if (ov1  && lat1  < 0) begin lat1  = n; c1  = so1;  end
      if (ov16 && lat16 < 0) begin lat16 = n; c16 = so16; end
    end
    checks++; if (lat4 !== 4) begin errors++; $display("FAIL %s lat4: got %0d expected 4", nm, lat4); end
    checks++; if (c4 !== exp) begin errors++; $display("FAIL %s data4: got %h expected %h", nm, c4, exp); end
    checks++; if (lat1 !== 16) begin errors++; $display("FAIL %s lat1: got %0d expected 16", nm, lat1); end
    checks++; if (c1 !== exp) begin errors++; $display("FAIL %s data1: got %h expected %h", nm, c1, exp); end
    checks++; if (lat16 !== 1) begin errors++; $display("FAIL %s lat16: got %0d expected 1", nm, lat16); end
    checks++; if (c16 !== exp) begin errors++; $display("FAIL %s data16: got %h expected %h", nm, c16, exp); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1; state_in = '1;
    repeat (2) @(negedge clk);
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", rdy4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", ov4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy4); end
    checks++; if (so4 !== 128'h0) begin errors++; $display("FAIL reset state_out: got %h expected 0", so4); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_all(128'h0, {16{8'h52}}, "zeros");
  endtask

  task automatic test_mapping();
    run_all(IN_SEQ, EXP_SEQ, "seq00");
    run_all(IN_HI, EXP_HI, "seqF0");
    run_all({16{8'h63}}, 128'h0, "all63");
  endtask

  task automatic test_backpressure();
    int bad_ov, bad_so, bad_rdy;
    bad_ov = 0; bad_so = 0; bad_rdy = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = IN_SEQ;
    @(negedge clk);
    in_valid  = 1'b0;
    state_in  = 128'h0;
    repeat (4) @(negedge clk);
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL bp done: got out_valid %b expected 1", ov4); end
    for (int n = 0; n < 10; n++) begin
      // Toggle state_in to show it is ignored while holding.
      state_in = {4{$urandom}};
      @(negedge clk);
      if (ov4 !== 1'b1) bad_ov++;
      if (so4 !== EXP_SEQ) bad_so++;
      if (rdy4 !== 1'b0) bad_rdy++;
    end
    checks++; if (bad_ov != 0) begin errors++; $display("FAIL bp hold out_valid: %0d low cycles, expected 0", bad_ov); end
    checks++; if (bad_so != 0) begin errors++; $display("FAIL bp hold state_out: %0d changed cycles, expected 0", bad_so); end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL bp hold in_ready: %0d high cycles, expected 0", bad_rdy); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL bp release out_valid: got %b expected 0", ov4); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b expected 1", rdy4); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_abort();
    int rose;
    rose = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = IN_SEQ;
    @(negedge clk);
    in_valid  = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL abort busy: got %b expected 0", busy4); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL abort in_ready: got %b expected 1", rdy4); end
    for (int n = 0; n < 8; n++) begin
      if (ov4 === 1'b1) rose++;
      @(negedge clk);
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL abort out_valid: rose %0d cycles, expected 0", rose); end
    run_all({16{8'h01}}, {16{8'h09}}, "post_abort");
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = IN_SEQ;
    @(negedge clk);
    in_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({rdy4, ov4, busy4} !== 3'b100) begin errors++; $display("FAIL rst_run ctrl: got %b expected 100", {rdy4, ov4, busy4}); end
    checks++; if (so4 !== 128'h0) begin errors++; $display("FAIL rst_run state_out: got %h expected 0", so4); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = IN_SEQ;
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL rst_done pre: got out_valid %b expected 1", ov4); end
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({rdy4, ov4, busy4} !== 3'b100) begin errors++; $display("FAIL rst_done ctrl: got %b expected 100", {rdy4, ov4, busy4}); end
    checks++; if (so4 !== 128'h0) begin errors++; $display("FAIL rst_done state_out: got %h expected 0", so4); end
    repeat (3) @(negedge clk);
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_done after: got out_valid %b expected 0", ov4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mapping();
    test_backpressure();
    test_abort();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
